// File: rtl/uart_pkg.sv
// Shared types and limits for the UART baud/sampling tick generator.
package uart_pkg;

  localparam int unsigned OSR_MIN    = 4;
  localparam int unsigned OSR_MAX    = 32;
  localparam int unsigned DIV_MIN    = 2;
  localparam int unsigned OSR_W      = 6;
  localparam int unsigned CFG_DIV_W  = 16;
  localparam int unsigned CFG_FRAC_W = 4;

  // One complete divisor / oversampling setting
  typedef struct packed {
    logic [CFG_DIV_W-1:0]  div_int;
    logic [CFG_FRAC_W-1:0] div_frac;
    logic [OSR_W-1:0]      osr;
  } cfg_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_e;

  // div_int >= 2 and an even oversampling ratio within [4, 32]
  function automatic logic cfg_legal(input cfg_t c);
    return (c.div_int >= CFG_DIV_W'(DIV_MIN)) &&
           (c.osr >= OSR_W'(OSR_MIN)) &&
           (c.osr <= OSR_W'(OSR_MAX)) &&
           !c.osr[0];
  endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: periods of div_int or div_int+1 clocks so that the
// long-run average period is div_int + div_frac/2^FRAC_W.
module uart_frac_divider #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              s_tick
);

  localparam int unsigned CW = DIV_W + 1;
  localparam int unsigned AW = FRAC_W + 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              carry;
  logic [CW-1:0]     last_cnt;
  logic [AW-1:0]     acc_sum;

  // Last count of the current period (period = div_int + carry)
  always_comb begin
    last_cnt = {1'b0, div_int} + CW'(carry) - CW'(1);
    acc_sum  = {1'b0, frac_acc} + {1'b0, div_frac};
    s_tick   = ({1'b0, div_cnt} == last_cnt);
  end

  // Period counter and fractional accumulator; carry stretches the next period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (clear) begin
      div_cnt  <= '0;
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (s_tick) begin
      div_cnt           <= '0;
      {carry, frac_acc} <= acc_sum;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud/sampling tick generator: fractional divider, oversample counter,
// mid-bit and bit-boundary decode, and a valid/ready runtime config port.
// DIV_W / FRAC_W must match the config record widths in uart_pkg.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W        = CFG_DIV_W,
  parameter int unsigned FRAC_W       = CFG_FRAC_W,
  parameter int unsigned DEF_DIV_INT  = 27,
  parameter int unsigned DEF_DIV_FRAC = 2,
  parameter int unsigned DEF_OSR      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic [OSR_W-1:0]  cfg_osr,
  output logic              cfg_err,
  output logic              s_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  cfg_state_e       state, state_nxt;
  cfg_t             act_cfg, pend_cfg, req_cfg;
  logic             en_q;
  logic             clear;
  logic             div_tick;
  logic             legal;
  logic             load_pend;
  logic             apply;
  logic             err_nxt;
  logic [OSR_W-1:0] osr_cnt, osr_nxt, osr_last, osr_half;

  // An en rise restarts the phase exactly like a resync pulse
  assign clear = !en || !en_q || resync;

  uart_frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .div_int  (DIV_W'(act_cfg.div_int)),
    .div_frac (FRAC_W'(act_cfg.div_frac)),
    .s_tick   (div_tick)
  );

  // Incoming config request and its legality
  always_comb begin
    req_cfg.div_int  = CFG_DIV_W'(cfg_div_int);
    req_cfg.div_frac = CFG_FRAC_W'(cfg_div_frac);
    req_cfg.osr      = cfg_osr;
    legal            = cfg_legal(req_cfg);
  end

  // Config handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CFG_IDLE;
    else          state <= state_nxt;
  end

  // Handshake next state: accept in IDLE, apply pending at a period wrap or restart
  always_comb begin
    state_nxt = state;
    load_pend = 1'b0;
    apply     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (cfg_valid) begin
          if (legal) begin
            load_pend = 1'b1;
            state_nxt = CFG_PEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CFG_PEND: begin
        if (div_tick || !en || resync) begin
          apply     = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  // Active/pending config, error pulse and enable history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_cfg.div_int  <= CFG_DIV_W'(DEF_DIV_INT);
      act_cfg.div_frac <= CFG_FRAC_W'(DEF_DIV_FRAC);
      act_cfg.osr      <= OSR_W'(DEF_OSR);
      pend_cfg         <= '0;
      cfg_err          <= 1'b0;
      en_q             <= 1'b0;
    end else begin
      en_q    <= en;
      cfg_err <= err_nxt;
      if (load_pend) pend_cfg <= req_cfg;
      if (apply)     act_cfg  <= pend_cfg;
    end
  end

  // Oversample position; out-of-range positions fold to 0 under a smaller new ratio
  always_comb begin
    osr_last = act_cfg.osr - OSR_W'(1);
    osr_half = (act_cfg.osr >> 1) - OSR_W'(1);
    osr_nxt  = osr_cnt;
    if (clear) begin
      osr_nxt = '0;
    end else if (div_tick) begin
      osr_nxt = (osr_cnt == osr_last) ? '0 : osr_cnt + OSR_W'(1);
      if (apply && (osr_nxt >= pend_cfg.osr)) osr_nxt = '0;
    end
  end

  // Oversample counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) osr_cnt <= '0;
    else          osr_cnt <= osr_nxt;
  end

  // Tick decode from registered state only
  always_comb begin
    cfg_ready = (state == CFG_IDLE);
    s_tick    = div_tick;
    mid_tick  = div_tick && (osr_cnt == osr_half);
    bit_tick  = div_tick && (osr_cnt == osr_last);
  end

endmodule
